// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode definitions: instruction constants and the queued entry type.
package if_id_queue_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  HALT_OPC  = 5'b00000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcinc;
    } iq_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake of the IF/ID instruction queue.
interface if_id_queue_if;

    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pcinc;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pcinc;
    logic        out_ready;

    modport master (
        output in_valid, in_instr, in_pcinc, out_ready,
        input  in_ready, out_valid, out_instr, out_pcinc
    );

    modport slave (
        input  in_valid, in_instr, in_pcinc, out_ready,
        output in_ready, out_valid, out_instr, out_pcinc
    );

endinterface

// File: rtl/if_id_queue_iq_ctrl.sv
// Queue bookkeeping: pointers, occupancy, push/pop/flush decisions and HALT tracking.
module if_id_queue_iq_ctrl #(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             in_is_halt,
    input  logic             head_is_halt,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             halt_pending,
    output logic             halt_seen
);

    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != CNT_W'(DEPTH)) && !halt_pending;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            halt_pending <= 1'b0;
            halt_seen    <= 1'b0;
        end else if (flush) begin
            // halt_seen survives a redirect; only reset clears it
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            halt_pending <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (push && in_is_halt) halt_pending <= 1'b1;
            if (pop && head_is_halt) halt_seen    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: entry storage and head output mux around the control block.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = if_id_queue_pkg::NOP_INSTR,
    parameter logic [4:0]  HALT_OPC  = if_id_queue_pkg::HALT_OPC,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    if_id_queue_if.slave     bus,
    output logic             halt_pending,
    output logic             halt_seen,
    output logic [CNT_W-1:0] count
);

    iq_entry_t        storage [DEPTH];
    iq_entry_t        head;
    logic             push;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = storage[rd_ptr];

    if_id_queue_iq_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (bus.in_valid),
        .out_ready    (bus.out_ready),
        .in_is_halt   (bus.in_instr[15:11] == HALT_OPC),
        .head_is_halt (head.instr[15:11] == HALT_OPC),
        .in_ready     (bus.in_ready),
        .out_valid    (bus.out_valid),
        .push         (push),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .halt_pending (halt_pending),
        .halt_seen    (halt_seen)
    );

    // Entry contents are don't-care until written; the empty case is masked below.
    always_ff @(posedge clk) begin
        if (push) storage[wr_ptr] <= '{instr: bus.in_instr, pcinc: bus.in_pcinc};
    end

    assign bus.out_instr = bus.out_valid ? head.instr : NOP_INSTR;
    assign bus.out_pcinc = bus.out_valid ? head.pcinc : 16'h0000;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic against a queue-based model.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       halt_pending;
    logic       halt_seen;
    logic [1:0] count;

    if_id_queue_if qif ();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (qif.slave),
        .halt_pending (halt_pending),
        .halt_seen    (halt_seen),
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mq [$];
    bit          m_hp;
    bit          m_hs;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (model_ok) assert (count <= 2'(DEPTH)) else $error("occupancy bound exceeded: %0d", count);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Compare outputs against the model, then advance both across one clock edge.
    task automatic cycle();
        int          sz;
        bit          e_ir, e_ov, do_push, do_pop, s_rst, s_flush;
        logic [31:0] e_head, in_word;
        sz     = mq.size();
        e_ir   = (sz != DEPTH) && !m_hp;
        e_ov   = (sz != 0);
        e_head = e_ov ? mq[0] : {NOP_INSTR, 16'h0000};
        if (model_ok) begin
            chk("in_ready",     32'(qif.in_ready),  32'(e_ir));
            chk("out_valid",    32'(qif.out_valid), 32'(e_ov));
            chk("out_instr",    32'(qif.out_instr), 32'(e_head[31:16]));
            chk("out_pcinc",    32'(qif.out_pcinc), 32'(e_head[15:0]));
            chk("count",        32'(count),         32'(sz));
            chk("halt_pending", 32'(halt_pending),  32'(m_hp));
            chk("halt_seen",    32'(halt_seen),     32'(m_hs));
        end
        s_rst   = rst;
        s_flush = flush;
        do_push = qif.in_valid && e_ir && !s_flush;
        do_pop  = e_ov && qif.out_ready && !s_flush;
        in_word = {qif.in_instr, qif.in_pcinc};
        @(posedge clk);
        #1;
        if (s_rst) begin
            mq.delete();
            m_hp     = 1'b0;
            m_hs     = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (s_flush) begin
                mq.delete();
                m_hp = 1'b0;
            end else begin
                if (do_pop) begin
                    if (mq[0][31:27] == HALT_OPC) m_hs = 1'b1;
                    void'(mq.pop_front());
                end
                if (do_push) begin
                    mq.push_back(in_word);
                    if (in_word[31:27] == HALT_OPC) m_hp = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input logic [15:0] ins, input logic [15:0] pc,
                         input bit ordy, input bit fl, input bit r);
        qif.in_valid  = v;
        qif.in_instr  = ins;
        qif.in_pcinc  = pc;
        qif.out_ready = ordy;
        flush         = fl;
        rst           = r;
        cycle();
    endtask

    initial begin
        logic [15:0] r_ins;
        qif.in_valid  = 1'b0;
        qif.in_instr  = 16'h0000;
        qif.in_pcinc  = 16'h0000;
        qif.out_ready = 1'b0;
        flush         = 1'b0;
        rst           = 1'b1;

        // reset then idle
        drive(0, 16'h0000, 16'h0000, 0, 0, 1);
        drive(0, 16'h0000, 16'h0000, 0, 0, 1);
        chk("rst_out_valid", 32'(qif.out_valid), 32'd0);
        chk("rst_out_instr", 32'(qif.out_instr), 32'h0800);
        chk("rst_in_ready",  32'(qif.in_ready),  32'd1);
        chk("rst_count",     32'(count),         32'd0);
        drive(0, 16'h0000, 16'h0000, 0, 0, 0);

        // fill and stall; third push dropped
        drive(1, 16'hC001, 16'h0002, 0, 0, 0);
        drive(1, 16'hC002, 16'h0004, 0, 0, 0);
        drive(1, 16'hC0FF, 16'h0006, 0, 0, 0);
        chk("full_count",    32'(count),         32'd2);
        chk("full_in_ready", 32'(qif.in_ready),  32'd0);
        chk("full_head",     32'(qif.out_instr), 32'hC001);
        chk("full_pcinc",    32'(qif.out_pcinc), 32'h0002);

        // streaming with pointer wrap
        drive(0, 16'h0000, 16'h0000, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 16'h4000 + 16'(i), 16'h0010 + 16'(2 * i), 1, 0, 0);
            chk("stream_head",  32'(qif.out_instr), 32'h4000 + 32'(i));
            chk("stream_count", 32'(count),         32'd1);
        end

        // flush with a full queue; flush-cycle instr must not land
        drive(0, 16'h0000, 16'h0000, 0, 1, 0);
        drive(1, 16'hC010, 16'h0020, 0, 0, 0);
        drive(1, 16'hC011, 16'h0022, 0, 0, 0);
        chk("pre_flush_count", 32'(count), 32'd2);
        drive(1, 16'hDEAD, 16'h0024, 0, 1, 0);
        chk("flush_count",     32'(count),         32'd0);
        chk("flush_out_valid", 32'(qif.out_valid), 32'd0);
        drive(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("flush_no_ghost",  32'(qif.out_instr), 32'h0800);

        // HALT blocks further input; dequeue sets halt_seen
        drive(1, 16'h0000, 16'h0100, 0, 0, 0);
        drive(1, 16'hC003, 16'h0102, 0, 0, 0);
        chk("halt_pending",  32'(halt_pending), 32'd1);
        chk("halt_in_ready", 32'(qif.in_ready), 32'd0);
        chk("halt_count",    32'(count),        32'd1);
        drive(0, 16'h0000, 16'h0000, 1, 0, 0);
        chk("halt_seen",     32'(halt_seen),    32'd1);
        drive(0, 16'h0000, 16'h0000, 0, 1, 0);
        chk("halt_seen_flush",  32'(halt_seen),    32'd1);
        chk("halt_pend_flush",  32'(halt_pending), 32'd0);

        // reset mid-operation overrides flush and handshake
        drive(1, 16'hC004, 16'h0200, 0, 0, 0);
        drive(1, 16'h0000, 16'h0202, 0, 0, 0);
        chk("mid_count", 32'(count),        32'd2);
        chk("mid_hp",    32'(halt_pending), 32'd1);
        drive(1, 16'hC005, 16'h0204, 1, 1, 1);
        chk("mid_rst_count", 32'(count),         32'd0);
        chk("mid_rst_hp",    32'(halt_pending),  32'd0);
        chk("mid_rst_hs",    32'(halt_seen),     32'd0);
        chk("mid_rst_ready", 32'(qif.in_ready),  32'd1);

        // random traffic
        repeat (400) begin
            r_ins = 16'($urandom);
            if ($urandom_range(7) == 0) r_ins[15:11] = HALT_OPC;
            drive(($urandom % 4) != 0, r_ins, 16'($urandom),
                  ($urandom % 3) != 0, $urandom_range(15) == 0, $urandom_range(63) == 0);
        end
        drive(0, 16'h0000, 16'h0000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
